// File: rtl/descriptor_memory_arbiter.sv
// Two-master arbiter for the single-port descriptor RAM: one access per clock,
// round-robin or fixed priority, with read data steered to the issuing master.
module descriptor_memory_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] grant;
    logic       rd_accept;
    logic       last_grant;   // 0 = m0, 1 = m1
    logic       rd_pend;
    logic       rd_owner;

    // A simultaneous read+write counts as a write.
    assign req = {m1_read | m1_write, m0_read | m0_write};
    assign wr  = {m1_write, m0_write};

    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            if (req == 2'b11) begin
                if (FIXED_PRIORITY != 0 || last_grant)
                    grant = 2'b01;
                else
                    grant = 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    assign rd_accept = |(grant & ~wr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (|grant)
                last_grant <= grant[1];
            rd_pend <= rd_accept;
            if (rd_accept)
                rd_owner <= grant[1];
        end
    end

    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];

    // Read data is broadcast; readdatavalid alone marks the owner.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend & ~rd_owner;
    assign m1_readdatavalid = rd_pend & rd_owner;

    assign mem_address    = grant[1] ? m1_address    : m0_address;
    assign mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
    assign mem_chipselect = |grant;
    assign mem_write      = |(grant & wr);
    assign mem_clken      = reset_n;

endmodule

// File: tb/tb_descriptor_memory_arbiter.sv
// Bench for descriptor_memory_arbiter: directed scenarios plus a randomized run
// against a queue-free behavioural model of grants, RAM contents and read returns.
module tb_descriptor_memory_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;

    logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, q;

    logic f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
    logic [DW-1:0] f_m0_readdata, f_m1_readdata;
    logic [AW-1:0] f_mem_address;
    logic [BW-1:0] f_mem_byteenable;
    logic f_mem_chipselect, f_mem_write, f_mem_clken;
    logic [DW-1:0] f_mem_writedata, fq;

    logic [DW-1:0] ram  [0:1023];
    logic [DW-1:0] fram [0:1023];
    logic [DW-1:0] ref_mem [0:15];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        for (int b = 0; b < BW; b++) r[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    // Behavioural RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
            else q <= ram[mem_address];
        end
        if (f_mem_clken && f_mem_chipselect) begin
            if (f_mem_write) fram[f_mem_address] <= merge(fram[f_mem_address], f_mem_writedata, f_mem_byteenable);
            else fq <= fram[f_mem_address];
        end
    end

    descriptor_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(q)
    );

    descriptor_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(f_m0_waitrequest),
        .m0_readdata(f_m0_readdata), .m0_readdatavalid(f_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(f_m1_waitrequest),
        .m1_readdata(f_m1_readdata), .m1_readdatavalid(f_m1_readdatavalid),
        .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
        .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write),
        .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken), .mem_readdata(fq)
    );

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0; m0_byteenable = '1; m1_byteenable = '1;
        m0_writedata = '0; m1_writedata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 0; idle(); m0_read = 1;
        #1;
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0 got=%b exp=1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait1 got=%b exp=0", m1_waitrequest); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", mem_chipselect); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", mem_write); end
        checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL reset_clken got=%b exp=0", mem_clken); end
        checks++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
        @(negedge clk);
        idle(); reset_n = 1;
        #1;
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL run_clken got=%b exp=1", mem_clken); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs got=%b exp=0", mem_chipselect); end
    endtask

    task automatic test_single_read();
        do_reset();
        ram[5] = 32'hDEADBEEF;
        @(negedge clk);
        m0_read = 1; m0_address = 10'h005;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_wait0 got=%b exp=0", m0_waitrequest); end
        checks++; if (mem_chipselect !== 1'b1 || mem_address !== 10'h005) begin errors++; $display("FAIL sr_mem got=cs%b a%h exp=cs1 a005", mem_chipselect, mem_address); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL sr_rdv0 got=%b exp=1", m0_readdatavalid); end
        checks++; if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data got=%h exp=deadbeef", m0_readdata); end
        checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_rdv1 got=%b exp=0", m1_readdatavalid); end
        @(negedge clk);
        #1;
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_rdv0_drop got=%b exp=0", m0_readdatavalid); end
    endtask

    task automatic test_contention();
        logic [DW-1:0] dat [0:1];
        dat[0] = 32'h1111_0010; dat[1] = 32'h2222_0020;
        do_reset();
        ram[10'h010] = dat[0]; ram[10'h020] = dat[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                m0_read = 1; m0_address = 10'h010; m1_read = 1; m1_address = 10'h020;
            end else idle();
            #1;
            if (i > 0) begin
                checks++; if (m0_readdatavalid !== ((i - 1) % 2 == 0) || m1_readdatavalid !== ((i - 1) % 2 == 1))
                    begin errors++; $display("FAIL ct_rdv cyc=%0d got=%b%b", i, m1_readdatavalid, m0_readdatavalid); end
                checks++; if (m0_readdata !== dat[(i - 1) % 2]) begin errors++; $display("FAIL ct_data cyc=%0d got=%h exp=%h", i, m0_readdata, dat[(i - 1) % 2]); end
            end
            if (i < 4) begin
                checks++; if (m0_waitrequest !== (i % 2 == 1) || m1_waitrequest !== (i % 2 == 0))
                    begin errors++; $display("FAIL ct_wait cyc=%0d got=w1%b w0%b", i, m1_waitrequest, m0_waitrequest); end
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        ram[10'h3FF] = 32'hAAAAAAAA;
        @(negedge clk);
        m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
        #1;
        checks++; if (m1_waitrequest !== 1'b0 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_accept got=w%b mw%b exp=w0 mw1", m1_waitrequest, mem_write); end
        checks++; if (mem_byteenable !== 4'h3 || mem_writedata !== 32'h12345678) begin errors++; $display("FAIL wr_bus got=be%h d%h", mem_byteenable, mem_writedata); end
        @(negedge clk);
        m1_write = 0; m1_read = 1;
        #1;
        checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL wr_noresp got=%b exp=0", m1_readdatavalid); end
        checks++; if (mem_write !== 1'b0 || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_accept got=mw%b w%b", mem_write, m1_waitrequest); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hAAAA5678) begin errors++; $display("FAIL wr_rd_data got=v%b %h exp=v1 aaaa5678", m1_readdatavalid, m1_readdata); end
    endtask

    task automatic test_fixed();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_read = 1; m0_address = 10'h001; m1_read = 1; m1_address = 10'h002;
            #1;
            checks++; if (f_m0_waitrequest !== 1'b0 || f_m1_waitrequest !== 1'b1)
                begin errors++; $display("FAIL fp_contend cyc=%0d got=w0%b w1%b exp=w0 0 w1 1", i, f_m0_waitrequest, f_m1_waitrequest); end
        end
        @(negedge clk);
        m0_read = 0;
        #1;
        checks++; if (f_m1_waitrequest !== 1'b0 || f_mem_address !== 10'h002) begin errors++; $display("FAIL fp_m1_grant got=w%b a%h exp=w0 a002", f_m1_waitrequest, f_mem_address); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        ram[10'h040] = 32'h0BADF00D;
        @(negedge clk);
        m1_read = 1; m1_address = 10'h040;
        #1;
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rm_accept got=%b exp=0", m1_waitrequest); end
        #1 reset_n = 0;
        #1;
        checks++; if (m1_readdatavalid !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_in_reset got=v%b w%b exp=v0 w1", m1_readdatavalid, m1_waitrequest); end
        checks++; if (mem_clken !== 1'b0 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL rm_clken got=ck%b cs%b exp=00", mem_clken, mem_chipselect); end
        @(negedge clk);
        #1;
        checks++; if (m1_readdatavalid !== 1'b0 || mem_clken !== 1'b0) begin errors++; $display("FAIL rm_hold got=v%b ck%b exp=00", m1_readdatavalid, mem_clken); end
        @(negedge clk);
        reset_n = 1; m0_read = 1; m0_address = 10'h040;
        #1;
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_m0_first got=w0%b w1%b exp=w0 0 w1 1", m0_waitrequest, m1_waitrequest); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rm_after got=v1%b v0%b exp=v1 0 v0 1", m1_readdatavalid, m0_readdatavalid); end
    endtask

    task automatic test_rw_collision();
        do_reset();
        ram[1] = 32'hFFFF0000;
        @(negedge clk);
        m0_read = 1; m0_write = 1; m0_address = 10'h001; m0_writedata = 32'h00000001; m0_byteenable = 4'hF;
        #1;
        checks++; if (mem_write !== 1'b1 || mem_chipselect !== 1'b1 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rw_is_write got=mw%b cs%b w%b exp=1 1 0", mem_write, mem_chipselect, m0_waitrequest); end
        @(negedge clk);
        m0_write = 0;
        #1;
        checks++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rw_no_valid got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h00000001) begin errors++; $display("FAIL rw_readback got=v%b %h exp=v1 00000001", m0_readdatavalid, m0_readdata); end
    endtask

    task automatic test_random();
        logic act [0:1], pw [0:1], pr [0:1];
        logic [AW-1:0] pa [0:1];
        logic [DW-1:0] pd [0:1];
        logic [BW-1:0] pbe [0:1];
        logic [1:0] wt, fwt, rdv;
        int last, g, fg, ev_owner, kind;
        bit ev_pend;
        logic [DW-1:0] ev_data;
        do_reset();
        for (int a = 0; a < 16; a++) begin ref_mem[a] = $urandom; ram[a] = ref_mem[a]; end
        for (int n = 0; n < 2; n++) begin act[n] = 0; pw[n] = 0; pr[n] = 0; pa[n] = '0; pd[n] = '0; pbe[n] = '0; end
        last = 1; ev_pend = 0; ev_owner = 0; ev_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rdv = {m1_readdatavalid, m0_readdatavalid};
            for (int n = 0; n < 2; n++) begin
                checks++; if (rdv[n] !== (ev_pend && ev_owner == n)) begin errors++; $display("FAIL rnd_rdv%0d cyc=%0d got=%b exp=%b", n, cyc, rdv[n], ev_pend && ev_owner == n); end
            end
            if (ev_pend) begin
                checks++; if (m0_readdata !== ev_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, m0_readdata, ev_data); end
            end
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(0, 3) != 0) begin
                    kind = $urandom_range(0, 3);
                    act[n] = 1; pw[n] = (kind < 2); pr[n] = (kind != 0);
                    pa[n] = AW'($urandom_range(0, 15)); pd[n] = $urandom; pbe[n] = BW'($urandom_range(0, 15));
                end
            end
            m0_read = act[0] & pr[0]; m0_write = act[0] & pw[0]; m0_address = pa[0]; m0_writedata = pd[0]; m0_byteenable = pbe[0];
            m1_read = act[1] & pr[1]; m1_write = act[1] & pw[1]; m1_address = pa[1]; m1_writedata = pd[1]; m1_byteenable = pbe[1];
            #1;
            if (act[0] && act[1]) begin g = (last == 1) ? 0 : 1; fg = 0; end
            else if (act[0]) begin g = 0; fg = 0; end
            else if (act[1]) begin g = 1; fg = 1; end
            else begin g = -1; fg = -1; end
            wt = {m1_waitrequest, m0_waitrequest};
            fwt = {f_m1_waitrequest, f_m0_waitrequest};
            for (int n = 0; n < 2; n++) begin
                checks++; if (wt[n] !== (act[n] && g != n)) begin errors++; $display("FAIL rnd_wait%0d cyc=%0d got=%b exp=%b", n, cyc, wt[n], act[n] && g != n); end
                checks++; if (fwt[n] !== (act[n] && fg != n)) begin errors++; $display("FAIL rnd_fpwait%0d cyc=%0d got=%b exp=%b", n, cyc, fwt[n], act[n] && fg != n); end
            end
            checks++; if (mem_chipselect !== (g >= 0) || mem_write !== (g >= 0 && pw[g < 0 ? 0 : g]))
                begin errors++; $display("FAIL rnd_mem cyc=%0d got=cs%b mw%b", cyc, mem_chipselect, mem_write); end
            ev_pend = 0;
            if (g >= 0) begin
                checks++; if (mem_address !== pa[g]) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_address, pa[g]); end
                last = g;
                if (pw[g]) ref_mem[pa[g]] = merge(ref_mem[pa[g]], pd[g], pbe[g]);
                else begin ev_pend = 1; ev_owner = g; ev_data = ref_mem[pa[g]]; end
                act[g] = 0;
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        for (int a = 0; a < 1024; a++) begin ram[a] = '0; fram[a] = '0; end
        q = '0; fq = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_fixed();
        test_reset_mid_read();
        test_rw_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/descriptor_memory_arbiter.md
# descriptor_memory_arbiter

Two-master arbiter sharing the single-port 1024×32 descriptor RAM between the Nios II data master (m0) and the SGDMA descriptor fetcher (m1). It issues at most one access per clock to the RAM. It tracks the RAM's one-cycle read latency and returns each read word, with a valid strobe, only to the master that issued it. It sits between the system interconnect and the RAM's s1 port and is the RAM's only client.

## Interface
Parameters:
- ADDR_W, 10, word address width (RAM depth = 2^ADDR_W)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = m0 always wins contention

Ports (N = 0, 1):
- clk  in  1  single system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  word address
- mN_byteenable  in  DATA_W/8  write byte lanes (ignored on reads)
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  request not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata holds the word for mN's accepted read
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; tied 1 while reset_n high, 0 in reset
- mem_readdata  in  DATA_W  RAM q; valid one cycle after the address is sampled

## Operation
- reqN = mN_read | mN_write. If read and write are both high, the access is treated as a write.
- Grant is combinational each cycle from req0, req1 and the last_grant register.
  - Only one requester: that requester is granted.
  - Both requesting, round-robin: grant the requester that is not last_grant.
  - Both requesting, FIXED_PRIORITY=1: grant m0.
- last_grant updates to the granted requester on every granted cycle and holds on idle cycles. Its reset value is m1, so m0 wins the first contention.
- Granted cycle drives the granted master's signals onto the RAM port:
  - mem_address, mem_byteenable, mem_writedata from the granted master
  - mem_chipselect = 1
  - mem_write = the granted master's write
- No grant: mem_chipselect = 0, mem_write = 0. The other mem_* outputs hold the m0 values; they are don't-care.
- mN_waitrequest = reqN & ~grantN, so it is 0 when the master is idle. A master holds its request stable until waitrequest is low.
- Read tracking:
  - A granted read sets registered rd_pend and rd_owner.
  - In the next cycle, mOwner_readdatavalid = 1, and the other master's readdatavalid = 0.
  - rd_pend clears on any cycle without a granted read.
- mN_readdata = mem_readdata for both masters, unqualified; readdatavalid is the only qualifier.
- Writes complete on acceptance. They return no response.
- A read to an address written the previous cycle returns the new data, because the RAM sees the accesses in order.
- Reset (reset_n low):
  - grants forced to 0, mem_chipselect = 0, mem_write = 0, mem_clken = 0
  - mN_waitrequest = reqN
  - rd_pend = 0, last_grant = m1
  - both readdatavalid = 0 immediately (asynchronous)
- Reset during a pending read drops that read; no valid is ever issued for it.

## Timing
- Accept-to-readdatavalid latency is exactly 1 cycle; a continuous read throughput of 1 word/clock is sustained.
- Back-to-back reads from alternating masters produce valids on consecutive cycles, each going to the correct owner.
- Under continuous contention in round-robin mode, each master gets every other cycle. Worst-case wait is 1 cycle.
- Under FIXED_PRIORITY=1, m1 can starve; this is an accepted property of that mode.
- Outputs at reset:
  - mN_readdatavalid = 0
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0
  - mN_waitrequest follows reqN
- The only registers are last_grant, rd_pend and rd_owner. All other paths from request to RAM are combinational.

## Test plan
- Single read: m0 reads addr 0x005 (RAM preloaded 0xDEADBEEF). Required: waitrequest 0 in cycle T; m0_readdatavalid = 1 in T+1 with data 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention after reset: m0 and m1 both read (0x010, 0x020) continuously. Required:
  - grant sequence m0, m1, m0, m1
  - waitrequest alternates between the two masters
  - valids alternate owner each cycle with the matching data
- Write then read: m1 writes 0x12345678 to 0x3FF with byteenable 0x3, then reads 0x3FF (prior contents 0xAAAAAAAA). Required: read returns 0xAAAA5678.
- Fixed priority: with FIXED_PRIORITY=1, both masters request for 4 cycles. Required: m0 granted all 4 cycles; m1_waitrequest held high for all 4; m1 granted on the first cycle m0 idles.
- Reset mid-read: m1 read accepted, then reset_n asserted before the next edge. Required:
  - m1_readdatavalid never asserts
  - after release, last_grant = m1 (m0 wins the next contention)
  - mem_clken = 0 throughout reset
- Read+write collision on one master: m0 asserts read and write together to 0x001 with data 0x00000001. Required: a write is performed and no readdatavalid is issued.
